// File: rtl/fft_result_reader.sv
// fft_result_reader: unloads the 8-point FFT working RAM in natural bin order
// onto a valid/ready stream carrying the bin index and a last-bin flag.
// A single fetch/present handshake per bin gives one sample every two cycles.
// Optional build macro FFT_READER_SCALE_EN: scale each captured part by
// 1/N_POINTS with round-half-up; undefined passes RAM data through unchanged.
module fft_result_reader #(
    parameter int N_POINTS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fft_done,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        read_addr,
    input  logic signed [DATA_W-1:0] ram_re,
    input  logic signed [DATA_W-1:0] ram_im,
    output logic signed [DATA_W-1:0] dout_re,
    output logic signed [DATA_W-1:0] dout_im,
    output logic [ADDR_W-1:0]        dout_index,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic                     busy,
    output logic                     unload_done,
    output logic                     overrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS - 1);

    state_t                   state_r;
    logic signed [DATA_W-1:0] cap_re_s;
    logic signed [DATA_W-1:0] cap_im_s;
    logic                     handshake_s;

`ifdef FFT_READER_SCALE_EN
    localparam logic signed [DATA_W:0] ROUND_HALF = (DATA_W + 1)'(2 ** (ADDR_W - 1));

    // Divide by N_POINTS with round-half-up; one guard bit keeps the add from overflowing.
    function automatic logic signed [DATA_W-1:0] scale_part(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W:0] ext;
        logic signed [DATA_W:0] sum;
        logic signed [DATA_W:0] shifted;
        ext     = {x[DATA_W-1], x};
        sum     = ext + ROUND_HALF;
        shifted = sum >>> ADDR_W;
        return DATA_W'(shifted);
    endfunction

    assign cap_re_s = scale_part(ram_re);
    assign cap_im_s = scale_part(ram_im);
`else
    assign cap_re_s = ram_re;
    assign cap_im_s = ram_im;
`endif

    assign handshake_s = dout_valid & dout_ready;

    // Unload FSM: walks bins 0..N-1, one RAM fetch and one output handshake per bin.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            rd_en       <= 1'b0;
            read_addr   <= '0;
            dout_re     <= '0;
            dout_im     <= '0;
            dout_index  <= '0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
            busy        <= 1'b0;
            unload_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            unload_done <= 1'b0;

            // A completion pulse while an unload is active is dropped, never queued.
            if (fft_done && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end

            case (state_r)
                ST_IDLE: begin
                    if (fft_done) begin
                        read_addr <= '0;
                        rd_en     <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ST_FETCH;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end

                ST_FETCH: begin
                    // RAM captured read_addr on the falling edge of this cycle.
                    dout_re    <= cap_re_s;
                    dout_im    <= cap_im_s;
                    dout_index <= read_addr;
                    dout_valid <= 1'b1;
                    dout_last  <= (read_addr == LAST_ADDR);
                    rd_en      <= 1'b0;
                    state_r    <= ST_PRESENT;
                end

                ST_PRESENT: begin
                    if (handshake_s && !dout_last) begin
                        dout_valid <= 1'b0;
                        read_addr  <= read_addr + ADDR_W'(1);
                        rd_en      <= 1'b1;
                        state_r    <= ST_FETCH;
                    end else if (handshake_s) begin
                        dout_valid  <= 1'b0;
                        dout_last   <= 1'b0;
                        unload_done <= 1'b1;
                        read_addr   <= '0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_PRESENT;
                    end
                end

                default: begin
                    rd_en      <= 1'b0;
                    read_addr  <= '0;
                    dout_valid <= 1'b0;
                    dout_last  <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_result_reader.sv
// Scoreboard bench for fft_result_reader: the frame driver pushes expected
// samples; a negedge monitor pops and compares on every handshake.
module tb_fft_result_reader;

    localparam int N      = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 24;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     fft_done = 1'b0;
    logic                     rd_en;
    logic [ADDR_W-1:0]        read_addr;
    logic signed [DATA_W-1:0] ram_re = '0;
    logic signed [DATA_W-1:0] ram_im = '0;
    logic signed [DATA_W-1:0] dout_re;
    logic signed [DATA_W-1:0] dout_im;
    logic [ADDR_W-1:0]        dout_index;
    logic                     dout_valid;
    logic                     dout_ready = 1'b1;
    logic                     dout_last;
    logic                     busy;
    logic                     unload_done;
    logic                     overrun;

    typedef struct {
        int re;
        int im;
        int idx;
        int last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   mem_re[N];
    int   mem_im[N];
    int   exp_re[N];
    int   exp_im[N];
    int   n_checks = 0;
    int   n_err    = 0;
    int   hs_count = 0;
    int   done_cyc;

    fft_result_reader #(.N_POINTS(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .fft_done(fft_done), .rd_en(rd_en), .read_addr(read_addr),
        .ram_re(ram_re), .ram_im(ram_im), .dout_re(dout_re), .dout_im(dout_im),
        .dout_index(dout_index), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .busy(busy), .unload_done(unload_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // RAM model: read port registered on the falling edge when enabled.
    always @(negedge clk) begin
        if (rd_en) begin
            ram_re <= DATA_W'(mem_re[read_addr]);
            ram_im <= DATA_W'(mem_im[read_addr]);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted sample must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && dout_valid && dout_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL extra_sample: got bin %0d expected none", dout_index);
            end else begin
                mon_e = exp_q.pop_front();
                check("sample_re", int'(dout_re), mon_e.re);
                check("sample_im", int'(dout_im), mon_e.im);
                check("sample_index", int'(dout_index), mon_e.idx);
                check("sample_last", int'(dout_last), mon_e.last);
            end
        end
    end

    function automatic int exp_part(input int x);
`ifdef FFT_READER_SCALE_EN
        return (x + 4) >>> 3;
`else
        return x;
`endif
    endfunction

    task automatic preload_default();
        for (int k = 0; k < N; k++) begin
            mem_re[k] = k * 1000;
            mem_im[k] = -k;
            exp_re[k] = exp_part(mem_re[k]);
            exp_im[k] = exp_part(mem_im[k]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_read_addr"}, int'(read_addr), 0);
        check({tag, "_dout_re"}, int'(dout_re), 0);
        check({tag, "_dout_im"}, int'(dout_im), 0);
        check({tag, "_dout_index"}, int'(dout_index), 0);
        check({tag, "_dout_valid"}, int'(dout_valid), 0);
        check({tag, "_dout_last"}, int'(dout_last), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_unload_done"}, int'(unload_done), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
    endtask

    // One frame: pulse fft_done after 'gap' edges, then steer ready/fft_done/rst per bin.
    // done_cycle = edges from the fft_done sample edge to unload_done, -1 timeout, -2 aborted.
    task automatic run_frame(input int gap, input int stall_bin, input int stall_len,
                             input int dup_bin, input int abort_bin, output int done_cycle);
        int  stall_cnt;
        bit  dup_done;
        stall_cnt  = 0;
        dup_done   = 1'b0;
        done_cycle = -1;
        hs_count   = 0;
        for (int k = 0; k < N; k++) begin
            exp_q.push_back('{re: exp_re[k], im: exp_im[k], idx: k, last: (k == N - 1) ? 1 : 0});
        end
        dout_ready = 1'b1;
        repeat (gap) @(posedge clk);
        #1 fft_done = 1'b1;
        @(posedge clk);
        #1 fft_done = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk);
            #1;
            if (unload_done) begin
                done_cycle = cyc;
                break;
            end
            if (dout_valid && (int'(dout_index) == abort_bin)) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1 rst = 1'b1;
                done_cycle = -2;
                return;
            end
            if (dout_valid && (int'(dout_index) == stall_bin) && (stall_cnt < stall_len)) begin
                dout_ready = 1'b0;
                stall_cnt++;
                check("stall_re", int'(dout_re), exp_re[stall_bin]);
                check("stall_im", int'(dout_im), exp_im[stall_bin]);
                check("stall_index", int'(dout_index), stall_bin);
                check("stall_read_addr", int'(read_addr), stall_bin);
                check("stall_rd_en", int'(rd_en), 0);
            end else begin
                dout_ready = 1'b1;
            end
            if (dout_valid && (int'(dout_index) == dup_bin) && !dup_done) begin
                fft_done = 1'b1;
                dup_done = 1'b1;
            end else begin
                fft_done = 1'b0;
            end
        end
        fft_done = 1'b0;
        if (done_cycle == -1) begin
            n_checks++;
            n_err++;
            $display("FAIL unload_timeout: got no unload_done expected within 100 cycles");
        end else begin
            check("busy_after_done", int'(busy), 0);
            check("sample_count", hs_count, N);
            check("queue_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        preload_default();
        #1;
        check_reset_outputs("reset");
        #20 rst = 1'b1;

        // Free-running unload.
        run_frame(1, -1, 0, -1, -1, done_cyc);
        check("latency_unload_done", done_cyc, 16);
        check("overrun_clean", int'(overrun), 0);
        @(posedge clk);
        #1;
        check("unload_done_pulse", int'(unload_done), 0);

        // Five-cycle stall on bin 3.
        repeat (3) @(posedge clk);
        run_frame(1, 3, 5, -1, -1, done_cyc);
        check("stall_unload_time", done_cyc, 21);

        // Back-to-back frames, second fft_done two cycles after unload_done.
        run_frame(1, -1, 0, -1, -1, done_cyc);
        run_frame(2, -1, 0, -1, -1, done_cyc);
        check("b2b_unload_time", done_cyc, 16);
        check("b2b_overrun", int'(overrun), 0);

        // fft_done while bin 2 is valid.
        repeat (3) @(posedge clk);
        run_frame(1, -1, 0, 2, -1, done_cyc);
        check("dup_unload_time", done_cyc, 16);
        check("dup_overrun", int'(overrun), 1);
        repeat (4) @(posedge clk);
        #1;
        check("dup_overrun_sticky", int'(overrun), 1);
        check("dup_no_restart_busy", int'(busy), 0);

        // Reset while bin 5 is valid, then a fresh frame from bin 0.
        run_frame(1, -1, 0, -1, 5, done_cyc);
        check("abort_taken", done_cyc, -2);
        run_frame(1, -1, 0, -1, -1, done_cyc);
        check("post_abort_time", done_cyc, 16);
        check("post_abort_overrun", int'(overrun), 0);

        // Small values exercising the rounding path when scaling is built in.
        mem_re[0] = 100;  mem_im[0] = -100;
        mem_re[1] = 4;    mem_im[1] = 3;
`ifdef FFT_READER_SCALE_EN
        exp_re[0] = 13;   exp_im[0] = -12;
        exp_re[1] = 1;    exp_im[1] = 0;
`else
        exp_re[0] = 100;  exp_im[0] = -100;
        exp_re[1] = 4;    exp_im[1] = 3;
`endif
        repeat (2) @(posedge clk);
        run_frame(1, -1, 0, -1, -1, done_cyc);
        check("small_values_time", done_cyc, 16);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_result_reader.md
Name: fft_result_reader

Overview:
- Unload engine for the 8-point FFT working RAM.
- After the FFT core signals completion, it walks the RAM result read port (read_addr, dataout_re/dataout_im) in natural order from bin 0 to bin N-1.
- Each sample is presented on a valid/ready output stream, with the bin index and a last flag.
- Sits between the RAM and the downstream consumer (UART/packer/spectrum logic), and is the read-side counterpart of the RAM initial-load path.

Parameters:
- N_POINTS, 8, number of FFT bins; power of two.
- ADDR_W, 3, log2(N_POINTS); width of read_addr and dout_index.
- DATA_W, 24, signed width of the real and imaginary parts.

Ports:
- clk  input  1  system clock; the RAM samples read_addr on the falling edge of this clock.
- rst  input  1  asynchronous active-low reset.
- fft_done  input  1  one-cycle pulse: RAM contents are final.
- rd_en  output  1  RAM read enable.
- read_addr  output  ADDR_W  RAM result read address.
- ram_re  input  DATA_W  RAM dataout_re, signed.
- ram_im  input  DATA_W  RAM dataout_im, signed.
- dout_re  output  DATA_W  output sample, real part.
- dout_im  output  DATA_W  output sample, imaginary part.
- dout_index  output  ADDR_W  bin number of the current sample.
- dout_valid  output  1  output sample valid.
- dout_ready  input  1  consumer accepts the sample.
- dout_last  output  1  high with dout_valid on bin N_POINTS-1.
- busy  output  1  unload in progress; high in any state other than IDLE.
- unload_done  output  1  one-cycle pulse after the last bin is accepted.
- overrun  output  1  sticky flag: fft_done arrived while busy; cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; rd_en=0, read_addr=0.
  - dout_re=0, dout_im=0, dout_index=0.
  - dout_valid=0, dout_last=0, unload_done=0, overrun=0.
- All state is registered on the rising edge of clk.
- State machine with three states: IDLE, FETCH, PRESENT.
- IDLE:
  - fft_done=1 -> read_addr<=0, rd_en<=1, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH (exactly 1 cycle):
  - The RAM captures read_addr on the falling edge inside this cycle.
  - At the next rising edge: dout_re<=ram_re, dout_im<=ram_im, dout_index<=read_addr, dout_valid<=1, dout_last<=(read_addr==N_POINTS-1).
  - Same edge: rd_en<=0, go to PRESENT.
- PRESENT:
  - dout_re, dout_im, dout_index and dout_last are held stable while dout_valid=1 and dout_ready=0; no limit on stall length.
  - On a handshake (valid & ready) with dout_last=0: dout_valid<=0, read_addr<=read_addr+1, rd_en<=1, go to FETCH.
  - On a handshake with dout_last=1: dout_valid<=0, dout_last<=0, unload_done<=1 for one cycle, read_addr<=0, go to IDLE.
- Timing:
  - Latency from fft_done to the first dout_valid is 2 rising edges.
  - Peak throughput is 1 sample per 2 cycles.
  - Minimum unload time is 2*N_POINTS cycles (16 with defaults).
- fft_done while busy:
  - Ignored; the current unload is not restarted.
  - overrun<=1.
  - fft_done in the same cycle as the last handshake is also an overrun and is not queued.
- read_addr wraps only through the explicit reset to 0 on the last bin; it never counts past N_POINTS-1.
- dout_ready while dout_valid=0 is ignored.
- Reset mid-unload aborts immediately to the reset values above; the partially sent frame is not resumed.
- Widths: data passes through unchanged (signed DATA_W) when the optional feature is off.

Optional Feature:
- Macro: FFT_READER_SCALE_EN.
- Defined:
  - On capture in FETCH, each part is scaled by 1/N_POINTS with round-half-up.
  - Scaled value = (x + 2^(ADDR_W-1)) >>> ADDR_W, computed at DATA_W+1 bits, then sign-extended back to DATA_W.
  - Example: 100 -> 13, -100 -> -12, 3 -> 0, 4 -> 1.
  - Latency is unchanged.
- Undefined: raw RAM values are passed through unchanged.

Test Plan:
- Preload the RAM model with re=k*1000, im=-k for k=0..7; pulse fft_done with dout_ready tied to 1.
  - 8 samples in order, bins 0..7, with matching values.
  - dout_last on bin 7 only; unload_done 16 cycles after fft_done; busy then drops.
- Same preload with dout_ready=0 for 5 cycles on bin 3.
  - dout_re=3000, dout_im=-3 and dout_index=3 held stable.
  - read_addr stays at 3 and rd_en=0 during the stall; bin 4 follows the release.
- Pulse fft_done again while bin 2 is valid.
  - overrun=1, stays set after unload_done.
  - The frame completes normally with exactly 8 samples; no restart.
- Assert rst low while bin 5 is valid.
  - All outputs are at reset values in the same cycle.
  - After rst is released and fft_done pulses again, the unload starts from bin 0.
- Macro defined; RAM bin0 re=100, im=-100, bin1 re=4, im=3.
  - Outputs: 13/-12, then 1/0.
- Two back-to-back frames, the second fft_done 2 cycles after unload_done.
  - Second frame is correct; overrun remains 0.
